// File: rtl/ukf_pkg.sv
// Shared definitions for the UKF FIFO sequencer: state encoding, default widths
// and the lower-triangle element count helper.
package ukf_pkg;

    localparam int DEF_DATA_W  = 128;
    localparam int DEF_N_LANES = 4;
    localparam int DEF_SIZE_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIAG  = 2'd1,
        ST_LOWER = 2'd2,
        ST_DRAIN = 2'd3
    } ukf_state_e;

    // Strictly-lower-triangle element count of an n x n matrix.
    function automatic int unsigned tri_count(input int unsigned n);
        if (n < 32'd2) begin
            return 32'd0;
        end else begin
            return (n * (n - 32'd1)) >> 1;
        end
    endfunction

endpackage

// File: rtl/ukf_rr_lane_ptr.sv
// Round-robin lane pointer for the lower-triangle FIFOs; wraps from the last
// lane back to lane 0 on each advance.
module ukf_rr_lane_ptr #(
    parameter int N_LANES = 4,
    localparam int PTR_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic             slow_clock,
    input  logic             rst,
    input  logic             adv,
    input  logic             clr,
    output logic [PTR_W-1:0] pointer
);

    logic [PTR_W-1:0] ptr_r;

    // Pointer register: clear has priority over advance.
    always_ff @(posedge slow_clock) begin
        if (rst || clr) begin
            ptr_r <= '0;
        end else if (adv) begin
            if (ptr_r == PTR_W'(N_LANES - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign pointer = ptr_r;

endmodule

// File: rtl/ukf_fifo_sequencer.sv
// Splits an incoming matrix stream (header, N diagonal words, N*(N-1)/2 lower
// words) into the diag FIFO and round-robin lower FIFO lanes.
module ukf_fifo_sequencer
    import ukf_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_LANES = DEF_N_LANES,
    parameter int SIZE_W  = DEF_SIZE_W
) (
    input  logic               slow_clock,
    input  logic               rst,
    input  logic               wr_enable,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               full_diag,
    input  logic               empty_diag,
    input  logic [N_LANES-1:0] full_lower,
    input  logic [N_LANES-1:0] empty_lower,
    input  logic               finish,
    output logic [SIZE_W-1:0]  matrix_size_out,
    output logic               fifo_wre_diag,
    output logic [N_LANES-1:0] fifo_wre_lower,
    output logic               fifo_rde_diag,
    output logic               start_begin,
    output logic               busy,
    output logic               wr_ready,
    output logic               stop_pipeline,
    output logic               err_overflow,
    output logic               err_size,
    output logic               err_abort
);

    localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int CNT_W = 2 * SIZE_W;

    ukf_state_e         state_r, state_next_s;
    logic [SIZE_W-1:0]  size_r;
    logic [SIZE_W-1:0]  diag_cnt_r;
    logic [CNT_W-1:0]   lower_cnt_r;
    logic [CNT_W-1:0]   lower_term_r;
    logic [N_LANES-1:0] lane_mask_r;
    logic               start_begin_r;
    logic               rde_r;
    logic               err_overflow_r;
    logic               err_size_r;
    logic               err_abort_r;

    logic [PTR_W-1:0]   lane_ptr_s;
    logic               accept_diag_s;
    logic               accept_lower_s;
    logic               overflow_s;
    logic               ready_s;
    logic               diag_last_s;
    logic               lower_last_s;
    logic               ptr_clr_s;
    logic [N_LANES-1:0] wre_lower_s;
    logic [SIZE_W-1:0]  hdr_size_s;
    int unsigned        hdr_tri_s;
    logic [N_LANES-1:0] hdr_mask_s;

    ukf_rr_lane_ptr #(.N_LANES(N_LANES)) u_lane_ptr (
        .slow_clock (slow_clock),
        .rst        (rst),
        .adv        (accept_lower_s),
        .clr        (ptr_clr_s),
        .pointer    (lane_ptr_s)
    );

    // Header decode: element count and the set of lanes that will ever hold data.
    always_comb begin
        hdr_size_s = wr_data[SIZE_W-1:0];
        hdr_tri_s  = tri_count(32'(hdr_size_s));
        hdr_mask_s = '0;
        for (int i = 0; i < N_LANES; i++) begin
            hdr_mask_s[i] = (32'(i) < hdr_tri_s);
        end
    end

    // Acceptance, ready, strobes and next state; finish outranks any write.
    always_comb begin
        ready_s        = 1'b0;
        accept_diag_s  = 1'b0;
        accept_lower_s = 1'b0;
        overflow_s     = 1'b0;
        wre_lower_s    = '0;
        state_next_s   = state_r;
        diag_last_s    = (diag_cnt_r == size_r - SIZE_W'(1));
        lower_last_s   = (lower_cnt_r == lower_term_r - CNT_W'(1));
        case (state_r)
            ST_IDLE: begin
                ready_s = 1'b1;
                if (wr_enable && (hdr_size_s >= SIZE_W'(2))) begin
                    state_next_s = ST_DIAG;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DIAG: begin
                ready_s       = ~full_diag;
                accept_diag_s = wr_enable & ready_s & ~finish & ~rst;
                overflow_s    = wr_enable & ~ready_s & ~finish;
                if (finish) begin
                    state_next_s = ST_IDLE;
                end else if (accept_diag_s && diag_last_s) begin
                    state_next_s = ST_LOWER;
                end else begin
                    state_next_s = ST_DIAG;
                end
            end
            ST_LOWER: begin
                ready_s        = ~full_lower[lane_ptr_s];
                accept_lower_s = wr_enable & ready_s & ~finish & ~rst;
                overflow_s     = wr_enable & ~ready_s & ~finish;
                if (accept_lower_s) begin
                    wre_lower_s[lane_ptr_s] = 1'b1;
                end else begin
                    wre_lower_s = '0;
                end
                if (finish) begin
                    state_next_s = ST_IDLE;
                end else if (accept_lower_s && lower_last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_LOWER;
                end
            end
            ST_DRAIN: begin
                ready_s = 1'b0;
                if (finish) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        ptr_clr_s = (state_next_s == ST_IDLE);
    end

    // Sequencer state, counters and sticky error flags.
    always_ff @(posedge slow_clock) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            size_r         <= '0;
            diag_cnt_r     <= '0;
            lower_cnt_r    <= '0;
            lower_term_r   <= '0;
            lane_mask_r    <= '0;
            start_begin_r  <= 1'b0;
            rde_r          <= 1'b0;
            err_overflow_r <= 1'b0;
            err_size_r     <= 1'b0;
            err_abort_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            rde_r   <= accept_diag_s && (diag_cnt_r == '0);
            if (accept_diag_s && (diag_cnt_r == '0)) begin
                start_begin_r <= 1'b1;
            end else if (state_next_s == ST_IDLE) begin
                start_begin_r <= 1'b0;
            end else begin
                start_begin_r <= start_begin_r;
            end
            if (state_r == ST_IDLE && wr_enable) begin
                size_r         <= hdr_size_s;
                lower_term_r   <= CNT_W'(hdr_tri_s);
                lane_mask_r    <= hdr_mask_s;
                err_overflow_r <= 1'b0;
                err_abort_r    <= 1'b0;
                err_size_r     <= (hdr_size_s < SIZE_W'(2));
            end else if ((state_r == ST_DIAG || state_r == ST_LOWER) && finish) begin
                err_abort_r <= 1'b1;
            end else if (overflow_s) begin
                err_overflow_r <= 1'b1;
            end else begin
                err_overflow_r <= err_overflow_r;
            end
            if (state_next_s == ST_IDLE) begin
                diag_cnt_r  <= '0;
                lower_cnt_r <= '0;
            end else if (accept_diag_s) begin
                diag_cnt_r <= diag_cnt_r + SIZE_W'(1);
            end else if (accept_lower_s) begin
                lower_cnt_r <= lower_cnt_r + CNT_W'(1);
            end else begin
                diag_cnt_r <= diag_cnt_r;
            end
        end
    end

    assign matrix_size_out = size_r;
    assign fifo_wre_diag   = accept_diag_s;
    assign fifo_wre_lower  = wre_lower_s;
    assign fifo_rde_diag   = rde_r;
    assign start_begin     = start_begin_r;
    assign busy            = (state_r != ST_IDLE);
    assign wr_ready        = ready_s;
    assign stop_pipeline   = start_begin_r & (empty_diag | (|(empty_lower & lane_mask_r)));
    assign err_overflow    = err_overflow_r;
    assign err_size        = err_size_r;
    assign err_abort       = err_abort_r;

endmodule

// File: tb/tb_ukf_fifo_sequencer.sv
// Scoreboard bench: stimulus queues the expected write destination of every
// word; a negedge monitor pops and compares whenever a write strobe fires.
module tb_ukf_fifo_sequencer;

    localparam int DATA_W  = 128;
    localparam int N_LANES = 4;
    localparam int SIZE_W  = 4;
    localparam int DIAG_ID = -1;

    logic               slow_clock = 1'b0;
    logic               rst = 1'b1;
    logic               wr_enable = 1'b0;
    logic [DATA_W-1:0]  wr_data = '0;
    logic               full_diag = 1'b0;
    logic               empty_diag = 1'b0;
    logic [N_LANES-1:0] full_lower = '0;
    logic [N_LANES-1:0] empty_lower = '0;
    logic               finish = 1'b0;
    logic [SIZE_W-1:0]  matrix_size_out;
    logic               fifo_wre_diag;
    logic [N_LANES-1:0] fifo_wre_lower;
    logic               fifo_rde_diag;
    logic               start_begin;
    logic               busy;
    logic               wr_ready;
    logic               stop_pipeline;
    logic               err_overflow;
    logic               err_size;
    logic               err_abort;

    int checks = 0;
    int errors = 0;
    int rde_cnt = 0;
    int rde_base = 0;
    int exp_q[$];

    ukf_fifo_sequencer #(.DATA_W(DATA_W), .N_LANES(N_LANES), .SIZE_W(SIZE_W)) dut (
        .slow_clock      (slow_clock),
        .rst             (rst),
        .wr_enable       (wr_enable),
        .wr_data         (wr_data),
        .full_diag       (full_diag),
        .empty_diag      (empty_diag),
        .full_lower      (full_lower),
        .empty_lower     (empty_lower),
        .finish          (finish),
        .matrix_size_out (matrix_size_out),
        .fifo_wre_diag   (fifo_wre_diag),
        .fifo_wre_lower  (fifo_wre_lower),
        .fifo_rde_diag   (fifo_rde_diag),
        .start_begin     (start_begin),
        .busy            (busy),
        .wr_ready        (wr_ready),
        .stop_pipeline   (stop_pipeline),
        .err_overflow    (err_overflow),
        .err_size        (err_size),
        .err_abort       (err_abort)
    );

    always #5 slow_clock = ~slow_clock;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the next queued destination.
    always @(negedge slow_clock) begin
        int obs;
        obs = -2;
        if (fifo_rde_diag) rde_cnt++;
        if (fifo_wre_diag && (fifo_wre_lower != '0)) begin
            check("diag_and_lower_together", 1, 0);
        end
        if (fifo_wre_lower != '0) begin
            check("lower_onehot", int'($countones(fifo_wre_lower)), 1);
            for (int i = 0; i < N_LANES; i++) if (fifo_wre_lower[i]) obs = i;
        end
        if (fifo_wre_diag) obs = DIAG_ID;
        if (obs != -2) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", obs, -100);
            end else begin
                check("write_dest", obs, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic send(input int w);
        wr_enable = 1'b1;
        wr_data   = DATA_W'(w);
        cyc();
        wr_enable = 1'b0;
    endtask

    task automatic diag_words(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(DIAG_ID);
            send(32'h100 + k);
        end
    endtask

    task automatic lower_words(input int n, input int first_lane);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back((first_lane + k) % N_LANES);
            send(32'h200 + k);
        end
    endtask

    task automatic do_finish();
        finish = 1'b1;
        cyc();
        finish = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        check("rst_size", int'(matrix_size_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_start", int'(start_begin), 0);
        check("rst_errs", int'({err_overflow, err_size, err_abort}), 0);
        check("rst_rde", int'(fifo_rde_diag), 0);
        rst = 1'b0;

        // N=4 full matrix, no stalls
        rde_base = rde_cnt;
        send(4);
        check("n4_busy", int'(busy), 1);
        check("n4_size", int'(matrix_size_out), 4);
        check("n4_start_pre", int'(start_begin), 0);
        diag_words(4);
        check("n4_rde_pulses", rde_cnt - rde_base, 1);
        check("n4_start", int'(start_begin), 1);
        lower_words(6, 0);
        check("n4_drain_busy", int'(busy), 1);
        check("n4_drain_ready", int'(wr_ready), 0);
        send(32'h55);
        check("n4_drain_no_err", int'(err_overflow), 0);
        empty_diag = 1'b1; #1;
        check("n4_stop_diag_empty", int'(stop_pipeline), 1);
        empty_diag = 1'b0; #1;
        check("n4_stop_clear", int'(stop_pipeline), 0);
        do_finish();
        check("n4_idle", int'(busy), 0);
        check("n4_start_off", int'(start_begin), 0);
        check("n4_no_abort", int'(err_abort), 0);
        check("n4_q_empty", exp_q.size(), 0);

        // N=3: three lower words on lanes 0..2, lane 3 inactive
        send(3);
        diag_words(3);
        lower_words(3, 0);
        empty_lower = 4'b1000; #1;
        check("n3_stop_ignores_lane3", int'(stop_pipeline), 0);
        empty_lower = 4'b0100; #1;
        check("n3_stop_lane2", int'(stop_pipeline), 1);
        empty_lower = 4'b0000;
        do_finish();
        check("n3_q_empty", exp_q.size(), 0);

        // Overflow on lane 1, then resume on lane 1
        send(4);
        diag_words(4);
        lower_words(1, 0);
        full_lower = 4'b0010; #1;
        check("ovf_ready_low", int'(wr_ready), 0);
        send(32'h77);
        check("ovf_flag", int'(err_overflow), 1);
        full_lower = 4'b0000;
        lower_words(5, 1);
        check("ovf_sticky", int'(err_overflow), 1);
        check("ovf_drain_ready", int'(wr_ready), 0);
        do_finish();
        check("ovf_q_empty", exp_q.size(), 0);

        // Bad size, then a minimal N=2 matrix
        send(1);
        check("n1_err_size", int'(err_size), 1);
        check("n1_idle", int'(busy), 0);
        check("n1_ovf_cleared", int'(err_overflow), 0);
        send(2);
        check("n2_err_size_clr", int'(err_size), 0);
        check("n2_busy", int'(busy), 1);
        diag_words(2);
        lower_words(1, 0);
        check("n2_drain_ready", int'(wr_ready), 0);
        do_finish();
        check("n2_q_empty", exp_q.size(), 0);

        // finish colliding with the 3rd lower word
        send(4);
        diag_words(4);
        lower_words(2, 0);
        finish = 1'b1;
        send(32'h99);
        finish = 1'b0;
        check("abort_flag", int'(err_abort), 1);
        check("abort_idle", int'(busy), 0);
        check("abort_start_off", int'(start_begin), 0);
        check("abort_q_empty", exp_q.size(), 0);

        // Reset mid-DIAG, then clean restart
        send(4);
        diag_words(2);
        rst = 1'b1;
        send(32'h123);
        rst = 1'b0;
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_size", int'(matrix_size_out), 0);
        check("rst_mid_start", int'(start_begin), 0);
        check("rst_mid_errs", int'({err_overflow, err_size, err_abort}), 0);
        rde_base = rde_cnt;
        send(2);
        diag_words(2);
        check("restart_rde", rde_cnt - rde_base, 1);
        lower_words(1, 0);
        check("restart_drain", int'(wr_ready), 0);
        do_finish();
        check("restart_idle", int'(busy), 0);
        check("final_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ukf_fifo_sequencer.md
UKF_FIFO_SEQUENCER -- requirements
Module: ukf_fifo_sequencer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 128, meaning the data word width in bits.
REQ-002 The module SHALL have parameter N_LANES, default 4, meaning the number of lower-triangle FIFO lanes (>=1).
REQ-003 The module SHALL have parameter SIZE_W, default 4, meaning the matrix-size field width.
REQ-004 Port slow_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port wr_enable, input, 1 bit: an incoming word is valid this cycle.
REQ-007 Port wr_data, input, DATA_W bits: the incoming word; bits [SIZE_W-1:0] carry the matrix size N in the header word.
REQ-008 Ports full_diag and empty_diag, inputs, 1 bit each: the diag FIFO status flags.
REQ-009 Ports full_lower and empty_lower, inputs, N_LANES bits each: the per-lane lower FIFO status flags.
REQ-010 Port finish, input, 1 bit: downstream has completed the matrix.
REQ-011 Port matrix_size_out, output, SIZE_W bits: the captured N.
REQ-012 Port fifo_wre_diag, output, 1 bit: the diag FIFO write strobe.
REQ-013 Port fifo_wre_lower, output, N_LANES bits: the per-lane lower FIFO write strobes, at most one bit hot.
REQ-014 Port fifo_rde_diag, output, 1 bit: the single-cycle diag prime read.
REQ-015 Ports start_begin and busy, outputs, 1 bit each: the pipeline is enabled, and a matrix is in progress.
REQ-016 Port wr_ready, output, 1 bit: the current target can accept a word.
REQ-017 Port stop_pipeline, output, 1 bit: stall the downstream pipeline.
REQ-018 Ports err_overflow, err_size and err_abort, outputs, 1 bit each: sticky error flags.

Function
REQ-019 The FSM SHALL have states IDLE, DIAG, LOWER and DRAIN, encoded as a registered state with a combinational next-state.
REQ-020 In IDLE with wr_enable=1:
- header captured: matrix_size_out <= wr_data[SIZE_W-1:0]; all three error flags cleared.
- header word not written to any FIFO.
- if N<2: err_size set, remain in IDLE; else go to DIAG.
REQ-021 In DIAG:
- each accepted word asserts fifo_wre_diag in the same cycle, combinationally (wr_enable & ~full_diag).
- the diag counter increments per accepted word.
- after the Nth accepted diag word, go to LOWER.
REQ-022 fifo_rde_diag SHALL pulse high for exactly one cycle, the cycle after the first accepted diag word.
REQ-023 In LOWER, accepted words SHALL be distributed round-robin:
- first word to lane 0; lane pointer increments per accepted word; wraps from N_LANES-1 to 0.
- fifo_wre_lower[p] = wr_enable & ~full_lower[p].
REQ-024 The lower counter width SHALL be 2*SIZE_W bits, and the terminal count SHALL be N*(N-1)/2 computed at header capture. After the last accepted lower word, go to DRAIN.
REQ-025 In DRAIN, no write strobes SHALL assert, and finish=1 SHALL cause a return to IDLE on the next edge.
REQ-026 finish=1 in DIAG or LOWER SHALL set err_abort and return to IDLE; counters and lane pointer cleared.
REQ-027 wr_ready SHALL equal:
- 1 in IDLE;
- ~full_diag in DIAG;
- ~full_lower[p] in LOWER;
- 0 in DRAIN.
REQ-028 wr_enable=1 with wr_ready=0 in DIAG or LOWER SHALL set err_overflow; the word is dropped, with no strobe and no counter or pointer advance.
REQ-029 wr_enable in DRAIN SHALL be ignored, with no error raised.
REQ-030 start_begin SHALL be registered: high from the cycle after the first accepted diag word until return to IDLE.
REQ-031 busy SHALL be high in DIAG, LOWER and DRAIN.
REQ-032 stop_pipeline SHALL be combinational: start_begin & (empty_diag | OR over active lanes of empty_lower), where active lanes = lanes 0..min(N_LANES, N*(N-1)/2)-1.
REQ-033 Simultaneous finish and wr_enable in LOWER SHALL give priority to finish: the word is not written.

Reset
REQ-034 rst=1 SHALL, at the next slow_clock edge, put the state in IDLE and clear all of the following to 0: matrix_size_out, counters, lane pointer, start_begin, fifo_rde_diag and every error flag.
REQ-035 While rst=1, combinational strobes SHALL be 0; reset mid-matrix discards progress with no error flag.

Structure
REQ-036 A shared ukf_pkg SHALL hold the state encoding constants and the default DATA_W/SIZE_W/N_LANES values.
REQ-037 The lane pointer with wrap logic SHALL be a sub-module ukf_rr_lane_ptr (parameter N_LANES; inputs adv and clr; output pointer).

Verification
REQ-038 N=4, N_LANES=4, no stalls: header, then 4 diag words, then 6 lower words -> wre_diag x4; lanes 0,1,2,3,0,1; fifo_rde_diag one pulse; DRAIN; finish -> IDLE.
REQ-039 N=3, N_LANES=4: 3 lower words -> lanes 0,1,2; stop_pipeline ignores empty_lower[3]=1.
REQ-040 full_lower[1]=1 with wr_enable held at lane 1 -> no strobe, err_overflow=1, pointer holds; after full deasserts the word goes to lane 1.
REQ-041 Header N=1 -> err_size=1, state IDLE; next header N=2 clears err_size, with 2 diag words and 1 lower word.
REQ-042 finish asserted at the 3rd lower word of N=4 -> err_abort=1, no write that cycle, IDLE next.
REQ-043 rst pulsed during DIAG (2 of 4 words) -> IDLE, all outputs 0; a new header restarts cleanly.
